uart_tx_framer: RTL and testbench

UART transmit-side framer and serializer, the counterpart of the receive-side deframer. It accepts an 8-bit byte through a ready/send handshake and builds an 11-bit frame: start, 8 data bits LSB first, parity, stop. The frame is shifted out on the serial line, with each bit held for a programmable number of clock cycles. It sits between the host-side byte source and the tx pin, and produces exactly the frame format the receive path deframes.

---
 rtl/uart_tx_framer.sv | 130 +++++++++++++
 tb/tb_uart_tx_framer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// UART transmit framer: accepts a byte on a ready/send handshake and shifts out
// start, 8 data bits LSB first, parity and stop, each held for BAUD_DIV clocks.
module uart_tx_framer #(
  parameter int BAUD_DIV = 5208,
  parameter int CNT_W    = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send,
  input  logic [7:0] data_in,
  input  logic [1:0] parity_type,
  output logic       ready,
  output logic       active_flag,
  output logic       done_flag,
  output logic       tx
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       idx_q;
  logic [7:0]       shift_q;
  logic [1:0]       mode_q;
  logic             xor_q;
  logic             ready_q;
  logic             active_q;
  logic             done_q;
  logic             tx_q;
  logic             bit_end;

  // Modes 10/11 carry no parity; the slot is still sent, as a constant 1.
  function automatic logic parity_bit(input logic [1:0] mode, input logic data_xor);
    case (mode)
      2'b00:   parity_bit = ~data_xor;
      2'b01:   parity_bit = data_xor;
      default: parity_bit = 1'b1;
    endcase
  endfunction

  assign bit_end = (cnt_q == CNT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      ready_q  <= 1'b1;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      done_q <= 1'b0;
      if (state_q != IDLE) begin
        cnt_q <= bit_end ? '0 : cnt_q + CNT_W'(1);
      end
      unique case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (send) begin
            shift_q  <= data_in;
            mode_q   <= parity_type;
            xor_q    <= ^data_in;
            cnt_q    <= '0;
            idx_q    <= '0;
            state_q  <= START;
            ready_q  <= 1'b0;
            active_q <= 1'b1;
            tx_q     <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            idx_q   <= '0;
            tx_q    <= shift_q[0];
          end
        end
        // shift_q[0] is always the bit currently on the line
        DATA: begin
          if (bit_end) begin
            if (idx_q == 3'd7) begin
              state_q <= PARITY;
              tx_q    <= parity_bit(mode_q, xor_q);
            end else begin
              idx_q   <= idx_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b1;
            tx_q     <= 1'b1;
          end
        end
        default: begin
          state_q  <= IDLE;
          ready_q  <= 1'b1;
          active_q <= 1'b0;
          tx_q     <= 1'b1;
        end
      endcase
    end
  end

  assign ready       = ready_q;
  assign active_flag = active_q;
  assign done_flag   = done_q;
  assign tx          = tx_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: a cycle-indexed frame model checks every output on
// every cycle; directed frames pin the model against hand-computed bit patterns.
module tb_uart_tx_framer;

  localparam int BAUD = 4;
  localparam int FRAME_CYC = 11 * BAUD;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       send = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [1:0] parity_type = 2'b00;
  logic       ready, active_flag, done_flag, tx;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: m_t = 0 idle, 1..44 = cycle index inside the frame, 45 = done cycle.
  int          m_t = 0;
  logic [10:0] m_frame = '1;
  int          m_accepts = 0;

  logic tx_log  [1:46];
  logic rdy_log [1:46];
  logic dn_log  [1:46];

  uart_tx_framer #(.BAUD_DIV(BAUD), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .send(send), .data_in(data_in),
    .parity_type(parity_type), .ready(ready), .active_flag(active_flag),
    .done_flag(done_flag), .tx(tx)
  );

  always #5 clock = ~clock;

  function automatic logic [10:0] build_frame(input logic [7:0] d, input logic [1:0] p);
    int   ones;
    logic pb;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    if (p == 2'b00)      pb = ((ones % 2) == 0);
    else if (p == 2'b01) pb = ((ones % 2) == 1);
    else                 pb = 1'b1;
    return {1'b1, pb, d, 1'b0};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    if (reset) m_t = 0;
    else if (m_t >= 1 && m_t <= FRAME_CYC) m_t++;
    else if (send) begin
      m_frame = build_frame(data_in, parity_type);
      m_t = 1;
      m_accepts++;
    end else m_t = 0;
  end

  always @(negedge clock) begin
    if (chk_en) begin
      if (m_t >= 1 && m_t <= FRAME_CYC) begin
        chk("model_tx", int'(tx), int'(m_frame[(m_t - 1) / BAUD]));
        chk("model_ready", int'(ready), 0);
        chk("model_active", int'(active_flag), 1);
        chk("model_done", int'(done_flag), 0);
      end else begin
        chk("model_tx", int'(tx), 1);
        chk("model_ready", int'(ready), 1);
        chk("model_active", int'(active_flag), 0);
        chk("model_done", int'(done_flag), (m_t == FRAME_CYC + 1) ? 1 : 0);
      end
    end
  end

  // Called just after a rising edge in an idle cycle; logs cycles 1..46 after acceptance.
  task automatic send_and_log(input logic [7:0] d, input logic [1:0] p, input bit hold,
                              output logic [10:0] bits, output int low, output int done_at);
    bits = '0;
    low = 0;
    done_at = 0;
    data_in = d;
    parity_type = p;
    send = 1'b1;
    @(posedge clock); #1;
    if (!hold) send = 1'b0;
    for (int c = 1; c <= 46; c++) begin
      if (hold && c == 10) data_in = 8'h3C;
      @(negedge clock);
      tx_log[c]  = tx;
      rdy_log[c] = ready;
      dn_log[c]  = done_flag;
      if (c % BAUD == 2 && c <= FRAME_CYC) bits[(c - 1) / BAUD] = tx;
      if (!ready && c <= FRAME_CYC + 1) low++;
      if (done_flag && done_at == 0) done_at = c;
      @(posedge clock); #1;
    end
  endtask

  initial begin
    logic [10:0] bits;
    int low, done_at, seen_done, target;

    // Reset and quiet idle
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("idle_tx", int'(tx), 1);
      chk("idle_ready", int'(ready), 1);
      chk("idle_active", int'(active_flag), 0);
      chk("idle_done", int'(done_flag), 0);
    end
    @(posedge clock); #1;

    // 0xA5 even, odd; 0x00 no parity
    send_and_log(8'hA5, 2'b01, 1'b0, bits, low, done_at);
    chk("a5_even_bits", int'(bits), int'(11'b10101001010));
    chk("a5_even_busy", low, 44);
    chk("a5_even_done_at", done_at, 45);
    send_and_log(8'hA5, 2'b00, 1'b0, bits, low, done_at);
    chk("a5_odd_bits", int'(bits), int'(11'b11101001010));
    send_and_log(8'h00, 2'b10, 1'b0, bits, low, done_at);
    chk("00_none_bits", int'(bits), int'(11'b11000000000));
    chk("00_none_done_at", done_at, 45);

    // send held high, data changed mid-frame, back-to-back accept
    send_and_log(8'hA5, 2'b01, 1'b1, bits, low, done_at);
    send = 1'b0;
    chk("hold_first_bits", int'(bits), int'(11'b10101001010));
    chk("hold_done_cycle_tx", int'(tx_log[45]), 1);
    chk("hold_done_cycle_ready", int'(rdy_log[45]), 1);
    chk("hold_done_pulse", int'(dn_log[45]), 1);
    chk("hold_next_start_tx", int'(tx_log[46]), 0);
    chk("hold_next_ready", int'(rdy_log[46]), 0);
    repeat (50) @(posedge clock);
    #1;

    // Reset in the middle of data bit 3
    data_in = 8'hA5; parity_type = 2'b01; send = 1'b1;
    @(posedge clock); #1 send = 1'b0;
    repeat (16) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("abort_tx", int'(tx), 1);
    chk("abort_ready", int'(ready), 1);
    chk("abort_active", int'(active_flag), 0);
    seen_done = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (done_flag) seen_done++;
    end
    chk("abort_no_done", seen_done, 0);
    @(posedge clock); #1;
    send_and_log(8'h55, 2'b01, 1'b0, bits, low, done_at);
    chk("after_abort_55_bits", int'(bits), int'(11'b10010101010));
    chk("after_abort_done_at", done_at, 45);

    // Random traffic: data/parity/send toggling every cycle, rare resets
    target = m_accepts + 512;
    for (int cyc = 0; cyc < 60000 && m_accepts < target; cyc++) begin
      @(posedge clock); #1;
      send = ($urandom_range(3) != 0);
      data_in = 8'($urandom);
      parity_type = 2'($urandom_range(3));
      reset = ($urandom_range(2999) == 0);
    end
    send = 1'b0;
    reset = 1'b0;
    repeat (60) @(posedge clock);
    chk("random_frames_accepted", (m_accepts >= target) ? 1 : 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
